// File: rtl/linear_feedback_shift_register.sv
// Fibonacci LFSR with lock-up guard and optional period-wrap flag.
// Build option: define LFSR_PERIOD_FLAG_EN to add the fim_periodo output.
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high reset, loads the effective seed
//   sequencia   [1:WIDTH] state, bit 1 is the MSB and the feedback entry
//   fim_periodo (LFSR_PERIOD_FLAG_EN only) 1 in the cycle the state wraps
module linear_feedback_shift_register #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic           clock,
  input  logic           reset,
  output logic [1:WIDTH] sequencia
`ifdef LFSR_PERIOD_FLAG_EN
  ,
  output logic           fim_periodo
`endif
);

  generate
    if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
      $error("linear_feedback_shift_register: WIDTH must be 3..8");
    end
  endgenerate

  // Tap masks written over positions [1:8]; position n is bit index n.
  function automatic logic [1:8] tap_mask(input int w);
    logic [1:8] m;
    m = 8'b0000_0000;
    unique case (w)
      3: m = 8'b0110_0000;
      4: m = 8'b0011_0000;
      5: m = 8'b0010_1000;
      6: m = 8'b0000_1100;
      7: m = 8'b0000_0110;
      8: m = 8'b0001_1101;
      default: m = 8'b0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [1:8] TAP8 = tap_mask(WIDTH);
  localparam logic [1:WIDTH] TAPS = TAP8[1:WIDTH];

  // An all-zero seed would lock the register, so fall back to MSB-only.
  localparam logic [1:WIDTH] SEED_EFF =
    (SEED == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : SEED;

  logic [1:WIDTH] state;
  logic [1:WIDTH] shifted;
  logic [1:WIDTH] nxt;
  logic           feedback;
  logic           lockup;

  assign feedback = ^(state & TAPS);
  assign shifted  = {feedback, state[1:WIDTH-1]};
  assign lockup   = (state == '0);
  assign nxt      = lockup ? SEED_EFF : shifted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SEED_EFF;
    end else begin
      state <= nxt;
    end
  end

  assign sequencia = state;

`ifdef LFSR_PERIOD_FLAG_EN
  // Only a wrap through feedback counts; reset and lock-up recovery do not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fim_periodo <= 1'b0;
    end else begin
      fim_periodo <= !lockup && (shifted == SEED_EFF);
    end
  end
`endif

endmodule

// File: tb/tb_linear_feedback_shift_register.sv
// Directed bench for linear_feedback_shift_register.
// Covers WIDTH=4 sequence, reset, lock-up recovery and WIDTH=8 period.
module tb_linear_feedback_shift_register;

  logic       clock;
  logic       reset;
  logic       reset8;
  logic [1:4] seq4;
  logic [1:8] seq8;
`ifdef LFSR_PERIOD_FLAG_EN
  logic       fim4;
  logic       fim8;
`endif

  int checks;
  int failures;

  linear_feedback_shift_register #(.WIDTH(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .sequencia  (seq4)
`ifdef LFSR_PERIOD_FLAG_EN
    ,
    .fim_periodo(fim4)
`endif
  );

  linear_feedback_shift_register #(.WIDTH(8)) dut8 (
    .clock      (clock),
    .reset      (reset8),
    .sequencia  (seq8)
`ifdef LFSR_PERIOD_FLAG_EN
    ,
    .fim_periodo(fim8)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] tbl [15];
  bit         seen4 [16];
  bit         seen8 [256];
  logic [7:0] v;

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0]  = 4'b1000; tbl[1]  = 4'b0100; tbl[2]  = 4'b0010;
    tbl[3]  = 4'b1001; tbl[4]  = 4'b1100; tbl[5]  = 4'b0110;
    tbl[6]  = 4'b1011; tbl[7]  = 4'b0101; tbl[8]  = 4'b1010;
    tbl[9]  = 4'b1101; tbl[10] = 4'b1110; tbl[11] = 4'b1111;
    tbl[12] = 4'b0111; tbl[13] = 4'b0011; tbl[14] = 4'b0001;
    for (int i = 0; i < 16; i++) seen4[i] = 1'b0;
    for (int i = 0; i < 256; i++) seen8[i] = 1'b0;

    reset  = 1'b1;
    reset8 = 1'b1;
    #1;
    chk("rst_async", {4'h0, seq4}, 8'h08);
`ifdef LFSR_PERIOD_FLAG_EN
    chk("rst_flag", {7'h0, fim4}, 8'h00);
`endif
    step();
    chk("rst_clk_hold", {4'h0, seq4}, 8'h08);
    step();
    chk("rst_clk_hold2", {4'h0, seq4}, 8'h08);

    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("seq_e%0d", k), {4'h0, seq4}, {4'h0, tbl[k % 15]});
      if (k <= 15) begin
        chk($sformatf("distinct_e%0d", k), {7'h0, seen4[seq4]}, 8'h00);
        seen4[seq4] = 1'b1;
      end
`ifdef LFSR_PERIOD_FLAG_EN
      chk($sformatf("flag_e%0d", k), {7'h0, fim4},
          {7'h0, (k == 15 || k == 30)});
`endif
    end
    chk("nonzero_seen", {7'h0, seen4[0]}, 8'h00);

    for (int k = 1; k <= 6; k++) step();
    chk("mid_1011", {4'h0, seq4}, 8'h0b);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_async", {4'h0, seq4}, 8'h08);
`ifdef LFSR_PERIOD_FLAG_EN
    chk("mid_rst_flag", {7'h0, fim4}, 8'h00);
`endif
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("after_rst_0100", {4'h0, seq4}, 8'h04);

    @(negedge clock);
    force dut4.state = 4'b0000;
    #1;
    chk("forced_zero", {4'h0, seq4}, 8'h00);
    release dut4.state;
    step();
    chk("lockup_seed", {4'h0, seq4}, 8'h08);
`ifdef LFSR_PERIOD_FLAG_EN
    chk("lockup_flag", {7'h0, fim4}, 8'h00);
`endif
    step();
    chk("lockup_next", {4'h0, seq4}, 8'h04);

    chk("w8_rst", seq8, 8'h80);
    @(negedge clock);
    reset8 = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      step();
      v = seq8;
      if (k < 255) begin
        chk($sformatf("w8_new_e%0d", k),
            {7'h0, (v != 8'h00 && v != 8'h80 && !seen8[v])}, 8'h01);
      end
      seen8[v] = 1'b1;
`ifdef LFSR_PERIOD_FLAG_EN
      chk($sformatf("w8_flag_e%0d", k), {7'h0, fim8}, {7'h0, (k == 255)});
`endif
    end
    chk("w8_wrap", seq8, 8'h80);
    step();
    chk("w8_after_wrap", seq8, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
